// File: rtl/ttr_pkg.sv
// Shared types and phase codes for the TTR phase controller.
package ttr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PH0  = 3'd1,
    ST_PH1  = 3'd2,
    ST_PH2  = 3'd3,
    ST_VOTE = 3'd4
  } ttr_state_t;

  localparam logic [1:0] TTR_CTR_IDLE = 2'b11;
  localparam logic [1:0] TTR_PH0      = 2'd0;
  localparam logic [1:0] TTR_PH1      = 2'd1;
  localparam logic [1:0] TTR_PH2      = 2'd2;

endpackage

// File: rtl/ttr_voter.sv
// Combinational bitwise 2-of-3 voter with word-level disagreement flags.
module ttr_voter #(
  parameter int W = 8
) (
  input  logic [W-1:0] s0,
  input  logic [W-1:0] s1,
  input  logic [W-1:0] s2,
  output logic [W-1:0] maj,
  output logic         mismatch,
  output logic         fatal
);

  assign maj      = (s0 & s1) | (s1 & s2) | (s0 & s2);
  // s0==s1 and s1==s2 implies all equal, so two compares cover any disagreement.
  assign mismatch = (s0 != s1) | (s1 != s2);
  assign fatal    = (s0 != s1) & (s1 != s2) & (s0 != s2);

endmodule

// File: rtl/ttr_phase_ctrl.sv
// Phase sequencer for TTR chain cells: drives ctr through three windows, samples, votes.
// Optional saturating mismatch counter enabled by defining TTR_ERR_CNT_EN.
module ttr_phase_ctrl
  import ttr_pkg::*;
#(
  parameter int W      = 8,
  parameter int PH_LEN = 3,
  parameter int ERR_W  = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] samp_in,
  output logic [1:0]   ctr,
  output logic         busy,
  output logic [W-1:0] vote_out,
  output logic         vote_valid,
  output logic         mismatch,
  output logic         fatal
`ifdef TTR_ERR_CNT_EN
  ,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_cnt
`endif
);

  localparam int CW = (PH_LEN > 1) ? $clog2(PH_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PH_LEN - 1);

  ttr_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  s0_q, s1_q, s2_q;
  logic          ph_last;
  logic          in_phase;
  logic [W-1:0]  maj_c;
  logic          mm_c, fat_c;

  // Handshake: start is sampled only while IDLE; vote_valid is a one-cycle
  // pulse with no back-pressure, and results hold until the next VOTE.
  always_comb begin
    state_d  = state_q;
    ctr      = TTR_CTR_IDLE;
    in_phase = 1'b0;
    ph_last  = (cnt_q == CNT_LAST);
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_PH0;
      ST_PH0: begin
        ctr      = TTR_PH0;
        in_phase = 1'b1;
        if (ph_last) state_d = ST_PH1;
      end
      ST_PH1: begin
        ctr      = TTR_PH1;
        in_phase = 1'b1;
        if (ph_last) state_d = ST_PH2;
      end
      ST_PH2: begin
        ctr      = TTR_PH2;
        in_phase = 1'b1;
        if (ph_last) state_d = ST_VOTE;
      end
      ST_VOTE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (in_phase && (state_d == state_q)) cnt_d = cnt_q + 1'b1;
  end

  assign busy = (state_q != ST_IDLE);

  ttr_voter #(.W(W)) u_voter (
    .s0       (s0_q),
    .s1       (s1_q),
    .s2       (s2_q),
    .maj      (maj_c),
    .mismatch (mm_c),
    .fatal    (fat_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      vote_out   <= '0;
      vote_valid <= 1'b0;
      mismatch   <= 1'b0;
      fatal      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      vote_valid <= (state_q == ST_VOTE);
      if (ph_last && state_q == ST_PH0) s0_q <= samp_in;
      if (ph_last && state_q == ST_PH1) s1_q <= samp_in;
      if (ph_last && state_q == ST_PH2) s2_q <= samp_in;
      if (state_q == ST_VOTE) begin
        vote_out <= maj_c;
        mismatch <= mm_c;
        fatal    <= fat_c;
      end
    end
  end

`ifdef TTR_ERR_CNT_EN
  // Counts on the valid pulse itself so a same-cycle clear can win.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      err_cnt <= '0;
    end else if (vote_valid && mismatch && (err_cnt != {ERR_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule
